// File: rtl/uart_apb_arbiter.sv
// Round-robin arbiter sharing the UART's APB slave port between two hold-until-done requesters.
// Each grant runs one SETUP/ACCESS transfer with a pready watchdog, then returns data and error.
module uart_apb_arbiter #(
   parameter int APB_ADDR_WIDTH = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT        = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [1:0]                req_i,
   input  logic                      wr0_i,
   input  logic                      wr1_i,
   input  logic [APB_ADDR_WIDTH-1:0] addr0_i,
   input  logic [APB_ADDR_WIDTH-1:0] addr1_i,
   input  logic [DATA_WIDTH-1:0]     wdata0_i,
   input  logic [DATA_WIDTH-1:0]     wdata1_i,
   input  logic [DATA_WIDTH/8-1:0]   strb0_i,
   input  logic [DATA_WIDTH/8-1:0]   strb1_i,
   output logic [1:0]                done_o,
   output logic [DATA_WIDTH-1:0]     rdata_o,
   output logic                      err_o,
   output logic [APB_ADDR_WIDTH-1:0] paddr_o,
   output logic                      psel_o,
   output logic                      penable_o,
   output logic                      pwrite_o,
   output logic [DATA_WIDTH-1:0]     pwdata_o,
   output logic [DATA_WIDTH/8-1:0]   pstrb_o,
   input  logic [DATA_WIDTH-1:0]     prdata_i,
   input  logic                      pready_i,
   input  logic                      pslverr_i
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int WD_W   = $clog2(TIMEOUT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

   state_t                    state_q, state_d;
   logic                      last_q, last_d;
   logic                      grant_q, grant_d;
   logic [WD_W-1:0]           wd_q, wd_d;
   logic                      psel_q, psel_d;
   logic                      penable_q, penable_d;
   logic                      pwrite_q, pwrite_d;
   logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0]     pwdata_q, pwdata_d;
   logic [STRB_W-1:0]         pstrb_q, pstrb_d;
   logic [1:0]                done_q, done_d;
   logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
   logic                      err_q, err_d;
   logic                      pick;

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      grant_d   = grant_q;
      wd_d      = wd_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      pstrb_d   = pstrb_q;
      done_d    = 2'b00;
      rdata_d   = rdata_q;
      err_d     = err_q;
      pick      = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req_i) begin
               // On contention the requester not served last time wins.
               pick     = (req_i == 2'b11) ? ~last_q : req_i[1];
               grant_d  = pick;
               last_d   = pick;
               pwrite_d = pick ? wr1_i    : wr0_i;
               paddr_d  = pick ? addr1_i  : addr0_i;
               pwdata_d = pick ? wdata1_i : wdata0_i;
               pstrb_d  = pick ? strb1_i  : strb0_i;
               psel_d   = 1'b1;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            wd_d      = '0;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (pready_i) begin
               rdata_d   = pwrite_q ? '0 : prdata_i;
               err_d     = pslverr_i;
               psel_d    = 1'b0;
               penable_d = 1'b0;
               done_d    = grant_q ? 2'b10 : 2'b01;
               state_d   = DONE;
            end else if (wd_q == WD_LAST) begin
               rdata_d   = '0;
               err_d     = 1'b1;
               psel_d    = 1'b0;
               penable_d = 1'b0;
               done_d    = grant_q ? 2'b10 : 2'b01;
               state_d   = DONE;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         last_q    <= 1'b1;
         grant_q   <= 1'b0;
         wd_q      <= '0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pstrb_q   <= '0;
         done_q    <= 2'b00;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         grant_q   <= grant_d;
         wd_q      <= wd_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pstrb_q   <= pstrb_d;
         done_q    <= done_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

   assign done_o    = done_q;
   assign rdata_o   = rdata_q;
   assign err_o     = err_q;
   assign paddr_o   = paddr_q;
   assign psel_o    = psel_q;
   assign penable_o = penable_q;
   assign pwrite_o  = pwrite_q;
   assign pwdata_o  = pwdata_q;
   assign pstrb_o   = pstrb_q;

endmodule
